cp0_exc_commit: RTL and testbench

CP0_EXC_COMMIT -- requirements
Module: cp0_exc_commit

---
 rtl/cp0_exc_commit_pkg.sv | 68 ++++++
 rtl/cp0_exc_commit_if.sv | 24 ++
 rtl/cp0_exc_commit_timer.sv | 50 +++++
 rtl/cp0_exc_commit.sv | 137 +++++++++++++
 tb/tb_cp0_exc_commit.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_exc_commit_pkg.sv
// rtl/cp0_exc_commit_pkg.sv - shared CPU defines: exception types, CP0 register numbers, ExcCode values
package cp0_exc_commit_pkg;

    typedef enum logic [4:0] {
        EX_None                = 5'd0,
        EX_Interrupt           = 5'd1,
        EX_TLBModified         = 5'd2,
        EX_TLBRefillinIF       = 5'd3,
        EX_TLBInvalidinIF      = 5'd4,
        EX_RdTLBRefillinMEM    = 5'd5,
        EX_RdTLBInvalidinMEM   = 5'd6,
        EX_WrTLBRefillinMEM    = 5'd7,
        EX_WrTLBInvalidinMEM   = 5'd8,
        EX_WrongAddressinIF    = 5'd9,
        EX_RdWrongAddressinMEM = 5'd10,
        EX_WrWrongAddressinMEM = 5'd11,
        EX_Syscall             = 5'd12,
        EX_Break               = 5'd13,
        EX_ReservedInstruction = 5'd14,
        EX_CpU                 = 5'd15,
        EX_Overflow            = 5'd16,
        EX_Trap                = 5'd17,
        EX_Refetch             = 5'd18,
        EX_Eret                = 5'd19
    } exc_type_e;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_EBASE    = 5'd15;
    localparam logic [2:0] CP0_SEL_0    = 3'd0;
    localparam logic [2:0] CP0_SEL_EBASE = 3'd1;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_CPU  = 5'd11;
    localparam logic [4:0] EXC_OV   = 5'd12;
    localparam logic [4:0] EXC_TR   = 5'd13;

    function automatic logic [4:0] exc_code_of(exc_type_e t);
        case (t)
            EX_TLBModified:                            return EXC_MOD;
            EX_TLBRefillinIF, EX_TLBInvalidinIF,
            EX_RdTLBRefillinMEM, EX_RdTLBInvalidinMEM: return EXC_TLBL;
            EX_WrTLBRefillinMEM, EX_WrTLBInvalidinMEM: return EXC_TLBS;
            EX_WrongAddressinIF, EX_RdWrongAddressinMEM: return EXC_ADEL;
            EX_WrWrongAddressinMEM:                    return EXC_ADES;
            EX_Syscall:                                return EXC_SYS;
            EX_Break:                                  return EXC_BP;
            EX_ReservedInstruction:                    return EXC_RI;
            EX_CpU:                                    return EXC_CPU;
            EX_Overflow:                               return EXC_OV;
            EX_Trap:                                   return EXC_TR;
            default:                                   return EXC_INT;
        endcase
    endfunction

endpackage

// File: rtl/cp0_exc_commit_if.sv
// rtl/cp0_exc_commit_if.sv - exception-commit and MTC0 write bundle between the MEM stage and CP0
interface cp0_exc_commit_if;
    import cp0_exc_commit_pkg::*;

    logic        exc_valid;
    logic [4:0]  exc_type;
    logic [31:0] exc_pc;
    logic        exc_in_ds;
    logic [31:0] exc_badvaddr;
    logic        mtc0_we;
    logic [4:0]  mtc0_addr;
    logic [2:0]  mtc0_sel;
    logic [31:0] mtc0_wdata;

    modport master (
        output exc_valid, exc_type, exc_pc, exc_in_ds, exc_badvaddr,
        output mtc0_we, mtc0_addr, mtc0_sel, mtc0_wdata
    );

    modport slave (
        input exc_valid, exc_type, exc_pc, exc_in_ds, exc_badvaddr,
        input mtc0_we, mtc0_addr, mtc0_sel, mtc0_wdata
    );
endinterface

// File: rtl/cp0_exc_commit_timer.sv
// rtl/cp0_exc_commit_timer.sv - Count/Compare timer: half-rate Count and the timer interrupt flag
module cp0_timer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        toggle_q, toggle_d;
    logic        ti_q, ti_d;

    always_comb begin
        toggle_d  = ~toggle_q;
        count_d   = toggle_q ? count_q + 32'd1 : count_q;
        compare_d = compare_q;
        ti_d      = ti_q | (count_q == compare_q);
        if (count_we) begin
            count_d  = wdata;
            toggle_d = 1'b0;
        end
        // Writing Compare is the software acknowledge of the timer interrupt.
        if (compare_we) begin
            compare_d = wdata;
            ti_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q   <= '0;
            compare_q <= '0;
            toggle_q  <= 1'b0;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            toggle_q  <= toggle_d;
            ti_q      <= ti_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;
endmodule

// File: rtl/cp0_exc_commit.sv
// rtl/cp0_exc_commit.sv - CP0 register file with exception/ERET commit and MTC0/MFC0 access
module cp0_exc_commit
    import cp0_exc_commit_pkg::*;
#(
    parameter logic [31:0] EBASE_RESET = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        exc_valid,
    input  logic [4:0]  exc_type,
    input  logic [31:0] exc_pc,
    input  logic        exc_in_ds,
    input  logic [31:0] exc_badvaddr,
    input  logic        mtc0_we,
    input  logic [4:0]  mtc0_addr,
    input  logic [2:0]  mtc0_sel,
    input  logic [31:0] mtc0_wdata,
    input  logic [4:0]  mfc0_addr,
    input  logic [2:0]  mfc0_sel,
    output logic [31:0] mfc0_rdata,
    input  logic [5:0]  ext_int,
    output logic        status_bev,
    output logic [7:0]  status_im,
    output logic        status_exl,
    output logic        status_ie,
    output logic [7:0]  cause_ip,
    output logic [31:0] ebase,
    output logic [31:0] epc
);
    exc_type_e etype;
    logic      exc_take, eret, mtc0_ok;
    logic      wr_count, wr_compare;
    logic [31:0] count, compare;
    logic        ti;

    logic        bev_q, bev_d, exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
    logic [7:0]  im_q, im_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [5:0]  ip7_2_q, ip7_2_d;
    logic [1:0]  ip1_0_q, ip1_0_d;
    logic [31:0] epc_q, epc_d, badvaddr_q, badvaddr_d;
    logic [17:0] ebase_q, ebase_d;

    assign etype    = exc_type_e'(exc_type);
    assign exc_take = exc_valid && !(etype inside {EX_None, EX_Refetch, EX_Eret});
    assign eret     = exc_valid && (etype == EX_Eret);
    // Any committing exception or ERET squashes the MTC0 in the same cycle.
    assign mtc0_ok    = mtc0_we && !exc_take && !eret;
    assign wr_count   = mtc0_ok && mtc0_addr == CP0_COUNT   && mtc0_sel == CP0_SEL_0;
    assign wr_compare = mtc0_ok && mtc0_addr == CP0_COMPARE && mtc0_sel == CP0_SEL_0;

    cp0_timer u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .count_we   (wr_count),
        .compare_we (wr_compare),
        .wdata      (mtc0_wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    always_comb begin
        bev_d = bev_q; im_d = im_q; exl_d = exl_q; ie_d = ie_q;
        bd_d = bd_q; exccode_d = exccode_q; ip1_0_d = ip1_0_q;
        epc_d = epc_q; badvaddr_d = badvaddr_q; ebase_d = ebase_q;
        ip7_2_d = {ext_int[5] | ti, ext_int[4:0]};

        if (mtc0_ok) begin
            case ({mtc0_addr, mtc0_sel})
                {CP0_STATUS, CP0_SEL_0}: begin
                    bev_d = mtc0_wdata[22];
                    im_d  = mtc0_wdata[15:8];
                    exl_d = mtc0_wdata[1];
                    ie_d  = mtc0_wdata[0];
                end
                {CP0_CAUSE, CP0_SEL_0}:     ip1_0_d = mtc0_wdata[9:8];
                {CP0_EPC, CP0_SEL_0}:       epc_d   = mtc0_wdata;
                {CP0_EBASE, CP0_SEL_EBASE}: ebase_d = mtc0_wdata[29:12];
                default: ;
            endcase
        end

        if (exc_take) begin
            exccode_d = exc_code_of(etype);
            exl_d     = 1'b1;
            // Nested exceptions keep the original return point.
            if (!exl_q) begin
                epc_d = exc_in_ds ? exc_pc - 32'd4 : exc_pc;
                bd_d  = exc_in_ds;
            end
            if (etype inside {EX_WrongAddressinIF, EX_TLBRefillinIF, EX_TLBInvalidinIF})
                badvaddr_d = exc_pc;
            else if (etype inside {EX_TLBModified, EX_RdTLBRefillinMEM, EX_RdTLBInvalidinMEM,
                                   EX_WrTLBRefillinMEM, EX_WrTLBInvalidinMEM,
                                   EX_RdWrongAddressinMEM, EX_WrWrongAddressinMEM})
                badvaddr_d = exc_badvaddr;
        end else if (eret) begin
            exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bev_q <= 1'b1; im_q <= '0; exl_q <= 1'b0; ie_q <= 1'b0;
            bd_q <= 1'b0; exccode_q <= '0; ip7_2_q <= '0; ip1_0_q <= '0;
            epc_q <= '0; badvaddr_q <= '0; ebase_q <= EBASE_RESET[29:12];
        end else begin
            bev_q <= bev_d; im_q <= im_d; exl_q <= exl_d; ie_q <= ie_d;
            bd_q <= bd_d; exccode_q <= exccode_d; ip7_2_q <= ip7_2_d; ip1_0_q <= ip1_0_d;
            epc_q <= epc_d; badvaddr_q <= badvaddr_d; ebase_q <= ebase_d;
        end
    end

    always_comb begin
        mfc0_rdata = '0;
        case ({mfc0_addr, mfc0_sel})
            {CP0_BADVADDR, CP0_SEL_0}: mfc0_rdata = badvaddr_q;
            {CP0_COUNT, CP0_SEL_0}:    mfc0_rdata = count;
            {CP0_COMPARE, CP0_SEL_0}:  mfc0_rdata = compare;
            {CP0_STATUS, CP0_SEL_0}:   mfc0_rdata = {9'b0, bev_q, 6'b0, im_q, 6'b0, exl_q, ie_q};
            {CP0_CAUSE, CP0_SEL_0}:    mfc0_rdata = {bd_q, ti, 14'b0, ip7_2_q, ip1_0_q,
                                                     1'b0, exccode_q, 2'b0};
            {CP0_EPC, CP0_SEL_0}:      mfc0_rdata = epc_q;
            {CP0_EBASE, CP0_SEL_EBASE}: mfc0_rdata = {2'b10, ebase_q, 12'b0};
            default: ;
        endcase
    end

    assign status_bev = bev_q;
    assign status_im  = im_q;
    assign status_exl = exl_q;
    assign status_ie  = ie_q;
    assign cause_ip   = {ip7_2_q, ip1_0_q};
    assign ebase      = {2'b10, ebase_q, 12'b0};
    assign epc        = epc_q;
endmodule

// File: tb/tb_cp0_exc_commit.sv
// tb/tb_cp0_exc_commit.sv - scoreboard bench for cp0_exc_commit
module tb_cp0_exc_commit;
    import cp0_exc_commit_pkg::*;

    localparam int K_RD = 0, K_IP = 1, K_EPC = 2, K_EBASE = 3, K_EXL = 4;

    typedef struct {
        string       name;
        int          kind;
        logic [4:0]  addr;
        logic [2:0]  sel;
        logic [31:0] mask;
        logic [31:0] exp;
    } item_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  mfc0_addr;
    logic [2:0]  mfc0_sel;
    logic [31:0] mfc0_rdata;
    logic [5:0]  ext_int;
    logic        status_bev, status_exl, status_ie;
    logic [7:0]  status_im, cause_ip;
    logic [31:0] ebase, epc;

    item_t sb[$];
    int    n_pass = 0;
    int    n_total = 0;

    cp0_exc_commit_if cif ();

    cp0_exc_commit #(.EBASE_RESET(32'h8000_0000)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .exc_valid    (cif.exc_valid),
        .exc_type     (cif.exc_type),
        .exc_pc       (cif.exc_pc),
        .exc_in_ds    (cif.exc_in_ds),
        .exc_badvaddr (cif.exc_badvaddr),
        .mtc0_we      (cif.mtc0_we),
        .mtc0_addr    (cif.mtc0_addr),
        .mtc0_sel     (cif.mtc0_sel),
        .mtc0_wdata   (cif.mtc0_wdata),
        .mfc0_addr    (mfc0_addr),
        .mfc0_sel     (mfc0_sel),
        .mfc0_rdata   (mfc0_rdata),
        .ext_int      (ext_int),
        .status_bev   (status_bev),
        .status_im    (status_im),
        .status_exl   (status_exl),
        .status_ie    (status_ie),
        .cause_ip     (cause_ip),
        .ebase        (ebase),
        .epc          (epc)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            item_t it;
            logic [31:0] act;
            it = sb.pop_front();
            mfc0_addr = it.addr;
            mfc0_sel  = it.sel;
            #1;
            case (it.kind)
                K_IP:    act = {24'b0, cause_ip};
                K_EPC:   act = epc;
                K_EBASE: act = ebase;
                K_EXL:   act = {31'b0, status_exl};
                default: act = mfc0_rdata;
            endcase
            n_total++;
            if ((act & it.mask) === it.exp) n_pass++;
            else $display("FAIL %s: got 0x%08h want 0x%08h", it.name, act & it.mask, it.exp);
        end
    end

    task automatic chk(string name, int kind, logic [4:0] a, logic [2:0] s,
                       logic [31:0] m, logic [31:0] e);
        item_t it;
        it.name = name; it.kind = kind; it.addr = a; it.sel = s; it.mask = m; it.exp = e;
        sb.push_back(it);
    endtask

    task automatic rd(string name, logic [4:0] a, logic [31:0] m, logic [31:0] e);
        chk(name, K_RD, a, (a == CP0_EBASE) ? CP0_SEL_EBASE : CP0_SEL_0, m, e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sync_check();
        @(negedge clk);
        #9;
    endtask

    task automatic mtc0(logic [4:0] a, logic [2:0] s, logic [31:0] d);
        cif.mtc0_we = 1'b1; cif.mtc0_addr = a; cif.mtc0_sel = s; cif.mtc0_wdata = d;
        tick();
        cif.mtc0_we = 1'b0;
    endtask

    task automatic set_exc(exc_type_e t, logic [31:0] pc, logic ds, logic [31:0] bva);
        cif.exc_valid = 1'b1; cif.exc_type = t; cif.exc_pc = pc;
        cif.exc_in_ds = ds; cif.exc_badvaddr = bva;
    endtask

    task automatic exc(exc_type_e t, logic [31:0] pc, logic ds, logic [31:0] bva);
        set_exc(t, pc, ds, bva);
        tick();
        cif.exc_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; ext_int = '0; mfc0_addr = '0; mfc0_sel = '0;
        cif.exc_valid = 1'b0; cif.exc_type = EX_None; cif.exc_pc = '0;
        cif.exc_in_ds = 1'b0; cif.exc_badvaddr = '0;
        cif.mtc0_we = 1'b0; cif.mtc0_addr = '0; cif.mtc0_sel = '0; cif.mtc0_wdata = '0;
        tick(); tick();
        resetn = 1'b1;

        repeat (10) tick();
        rd("rst_status", CP0_STATUS, 32'hFFFF_FFFF, 32'h0040_0000);
        rd("rst_ebase", CP0_EBASE, 32'hFFFF_FFFF, 32'h8000_0000);
        rd("rst_count", CP0_COUNT, 32'hFFFF_FFFF, 32'd5);
        rd("rst_epc", CP0_EPC, 32'hFFFF_FFFF, 32'h0);
        rd("unimpl_reg", 5'd3, 32'hFFFF_FFFF, 32'h0);
        chk("rst_ebase_port", K_EBASE, 0, 0, 32'hFFFF_FFFF, 32'h8000_0000);
        sync_check();
        n_total++;
        if (status_bev === 1'b1) n_pass++;
        else $display("FAIL rst_bev_port: got %0b want 1", status_bev);
        n_total++;
        if (status_exl === 1'b0) n_pass++;
        else $display("FAIL rst_exl_port: got %0b want 0", status_exl);
        n_total++;
        if (epc === 32'h0) n_pass++;
        else $display("FAIL rst_epc_port: got 0x%08h want 0x00000000", epc);

        mtc0(CP0_COMPARE, CP0_SEL_0, 32'd6);
        rd("cmp_wr_ti_clr", CP0_CAUSE, 32'h4000_0000, 32'h0);
        sync_check();
        tick(); tick();
        rd("ti_set", CP0_CAUSE, 32'h4000_0000, 32'h4000_0000);
        rd("count_at_cmp", CP0_COUNT, 32'hFFFF_FFFF, 32'd6);
        sync_check();
        tick();
        chk("ip7_set", K_IP, 0, 0, 32'h80, 32'h80);
        sync_check();
        mtc0(CP0_COMPARE, CP0_SEL_0, 32'd100);
        rd("ti_clr", CP0_CAUSE, 32'h4000_0000, 32'h0);
        sync_check();

        ext_int = 6'b000101;
        mtc0(CP0_CAUSE, CP0_SEL_0, 32'h0000_0300);
        ext_int = '0;
        chk("cause_ip", K_IP, 0, 0, 32'hFF, 32'h17);
        sync_check();

        mtc0(CP0_STATUS, CP0_SEL_0, 32'hFFFF_FFFF);
        rd("status_wmask", CP0_STATUS, 32'hFFFF_FFFF, 32'h0040_FF03);
        sync_check();
        mtc0(CP0_EBASE, CP0_SEL_EBASE, 32'hFFFF_FFFF);
        rd("ebase_wmask", CP0_EBASE, 32'hFFFF_FFFF, 32'hBFFF_F000);
        chk("ebase_port", K_EBASE, 0, 0, 32'hFFFF_FFFF, 32'hBFFF_F000);
        sync_check();
        mtc0(CP0_STATUS, CP0_SEL_0, 32'h0);

        exc(EX_Syscall, 32'hBFC0_0100, 1'b1, 32'h0);
        rd("sys_epc", CP0_EPC, 32'hFFFF_FFFF, 32'hBFC0_00FC);
        chk("sys_epc_port", K_EPC, 0, 0, 32'hFFFF_FFFF, 32'hBFC0_00FC);
        rd("sys_cause", CP0_CAUSE, 32'h8000_007C, 32'h8000_0020);
        chk("sys_exl", K_EXL, 0, 0, 32'h1, 32'h1);
        sync_check();
        exc(EX_Overflow, 32'h0000_0100, 1'b0, 32'h0);
        rd("ov_epc_kept", CP0_EPC, 32'hFFFF_FFFF, 32'hBFC0_00FC);
        rd("ov_cause", CP0_CAUSE, 32'h8000_007C, 32'h8000_0030);
        sync_check();

        exc(EX_Eret, 32'h0, 1'b0, 32'h0);
        rd("eret_status", CP0_STATUS, 32'hFFFF_FFFF, 32'h0);
        rd("eret_epc", CP0_EPC, 32'hFFFF_FFFF, 32'hBFC0_00FC);
        sync_check();
        exc(EX_Refetch, 32'hDEAD_0000, 1'b1, 32'h55);
        rd("refetch_status", CP0_STATUS, 32'hFFFF_FFFF, 32'h0);
        rd("refetch_epc", CP0_EPC, 32'hFFFF_FFFF, 32'hBFC0_00FC);
        rd("refetch_cause", CP0_CAUSE, 32'h8000_007C, 32'h8000_0030);
        rd("refetch_bva", CP0_BADVADDR, 32'hFFFF_FFFF, 32'h0);
        sync_check();

        set_exc(EX_RdWrongAddressinMEM, 32'h0000_2000, 1'b0, 32'h0000_1003);
        mtc0(CP0_EPC, CP0_SEL_0, 32'h0000_1234);
        cif.exc_valid = 1'b0;
        rd("adel_bva", CP0_BADVADDR, 32'hFFFF_FFFF, 32'h0000_1003);
        rd("adel_cause", CP0_CAUSE, 32'h8000_007C, 32'h0000_0010);
        rd("adel_epc", CP0_EPC, 32'hFFFF_FFFF, 32'h0000_2000);
        sync_check();
        exc(EX_WrongAddressinIF, 32'h0000_3001, 1'b0, 32'hFFFF_FFFF);
        rd("if_bva", CP0_BADVADDR, 32'hFFFF_FFFF, 32'h0000_3001);
        rd("if_epc_kept", CP0_EPC, 32'hFFFF_FFFF, 32'h0000_2000);
        sync_check();

        mtc0(CP0_COUNT, CP0_SEL_0, 32'hFFFF_FFFF);
        rd("count_wr", CP0_COUNT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        sync_check();
        tick();
        rd("count_hold", CP0_COUNT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        sync_check();
        tick();
        rd("count_wrap", CP0_COUNT, 32'hFFFF_FFFF, 32'h0);
        sync_check();

        resetn = 1'b0;
        set_exc(EX_Break, 32'h0000_4000, 1'b1, 32'h0);
        mtc0(CP0_EPC, CP0_SEL_0, 32'h0000_5555);
        cif.exc_valid = 1'b0;
        resetn = 1'b1;
        rd("rb_status", CP0_STATUS, 32'hFFFF_FFFF, 32'h0040_0000);
        rd("rb_cause", CP0_CAUSE, 32'hFFFF_FFFF, 32'h0);
        rd("rb_epc", CP0_EPC, 32'hFFFF_FFFF, 32'h0);
        rd("rb_bva", CP0_BADVADDR, 32'hFFFF_FFFF, 32'h0);
        sync_check();
        rd("rb_count", CP0_COUNT, 32'hFFFF_FFFF, 32'h0);
        rd("rb_compare", CP0_COMPARE, 32'hFFFF_FFFF, 32'h0);
        rd("rb_ebase", CP0_EBASE, 32'hFFFF_FFFF, 32'h8000_0000);
        sync_check();
        n_total++;
        if (status_bev === 1'b1) n_pass++;
        else $display("FAIL rb_bev_port: got %0b want 1", status_bev);
        n_total++;
        if (status_im === 8'h00) n_pass++;
        else $display("FAIL rb_im_port: got 0x%02h want 0x00", status_im);
        n_total++;
        if (status_exl === 1'b0) n_pass++;
        else $display("FAIL rb_exl_port: got %0b want 0", status_exl);
        n_total++;
        if (epc === 32'h0) n_pass++;
        else $display("FAIL rb_epc_port: got 0x%08h want 0x00000000", epc);
        n_total++;
        if (ebase === 32'h8000_0000) n_pass++;
        else $display("FAIL rb_ebase_port: got 0x%08h want 0x80000000", ebase);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
